// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: scoreboard entry layout, stage indices and the writer-match helper.
package cpu_pkg;

  // Entry address fields are sized for the widest register file in use (REG_ADDR_W <= 8).
  localparam int SB_ADDR_W = 8;

  localparam int STG_IF   = 0;
  localparam int STG_ID   = 1;
  localparam int STG_EXE  = 2;
  localparam int FWD_NONE = 0;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] waddr;
    logic                 reg_write;
    logic                 mem_read;
    logic [SB_ADDR_W-1:0] rs;
    logic [SB_ADDR_W-1:0] rt;
    logic                 uses_rs;
    logic                 uses_rt;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{
    valid: 1'b0, waddr: {SB_ADDR_W{1'b0}}, reg_write: 1'b0, mem_read: 1'b0,
    rs: {SB_ADDR_W{1'b0}}, rt: {SB_ADDR_W{1'b0}}, uses_rs: 1'b0, uses_rt: 1'b0
  };

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic writer_match(input sb_entry_t w, input logic [SB_ADDR_W-1:0] src,
                                        input logic uses);
    writer_match = w.valid && w.reg_write && (w.waddr != {SB_ADDR_W{1'b0}}) &&
                   (w.waddr == src) && uses;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard stage register with synchronous reset, advance enable and bubble insert.
module hazard_sb_entry
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      arst_n,
  input  logic      enable,
  input  logic      bubble,
  input  sb_entry_t d,
  output sb_entry_t q
);

  // Stage register: cleared on reset, holds while frozen, loads an empty slot on bubble.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      q <= SB_EMPTY;
    end else if (enable) begin
      q <= bubble ? SB_EMPTY : d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and squash controller over an N_STAGES-deep pipeline.
// Build option HAZARD_CTRL_FWD_EN enables EXE forwarding with load-use-only stalls.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int N_STAGES   = 5,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16,
  parameter int FWD_W      = $clog2(N_STAGES - 2)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_waddr,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  br_taken,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush_if_id,
  output logic [FWD_W-1:0]      fwd_a,
  output logic [FWD_W-1:0]      fwd_b,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int NE = N_STAGES - 2;  // entries for stages EXE..WB; sb[k] is stage 2+k

  sb_entry_t            sb [NE];
  sb_entry_t            id_entry;
  logic                 ins_bubble;
  logic                 haz;
  logic [FWD_W-1:0]     fa;
  logic [FWD_W-1:0]     fb;
  logic                 unused_sb;

  // Pack the ID instruction into scoreboard form.
  always_comb begin
    id_entry           = SB_EMPTY;
    id_entry.valid     = id_valid;
    id_entry.waddr     = SB_ADDR_W'(id_waddr);
    id_entry.reg_write = id_reg_write;
    id_entry.mem_read  = id_mem_read;
    id_entry.rs        = SB_ADDR_W'(id_rs);
    id_entry.rt        = SB_ADDR_W'(id_rt);
    id_entry.uses_rs   = id_uses_rs;
    id_entry.uses_rt   = id_uses_rt;
  end

  assign ins_bubble = bubble | flush_if_id | ~id_valid;

  for (genvar j = 0; j < NE; j++) begin : g_sb
    if (j == 0) begin : g_exe
      hazard_sb_entry u_entry (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .bubble(ins_bubble), .d(id_entry), .q(sb[j])
      );
    end else begin : g_older
      hazard_sb_entry u_entry (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .bubble(1'b0), .d(sb[j-1]), .q(sb[j])
      );
    end
  end

  // ID-side hazard: with forwarding only loads too young to reach WB in time stall.
  always_comb begin
    haz = 1'b0;
    for (int j = 0; j < NE; j++) begin
`ifdef HAZARD_CTRL_FWD_EN
      haz = haz | ((j <= N_STAGES - 5) && sb[j].mem_read &&
                   (writer_match(sb[j], id_entry.rs, id_uses_rs) ||
                    writer_match(sb[j], id_entry.rt, id_uses_rt)));
`else
      haz = haz | writer_match(sb[j], id_entry.rs, id_uses_rs) |
                  writer_match(sb[j], id_entry.rt, id_uses_rt);
`endif
    end
    haz = haz & id_valid;
  end

  // EXE operand sources: scan oldest to youngest so the youngest writer wins.
  always_comb begin
    fa = FWD_W'(FWD_NONE);
    fb = FWD_W'(FWD_NONE);
`ifdef HAZARD_CTRL_FWD_EN
    for (int k = NE - 1; k >= 1; k--) begin
      fa = ((!sb[k].mem_read || k == NE - 1) &&
            writer_match(sb[k], sb[0].rs, sb[0].uses_rs)) ? FWD_W'(k) : fa;
      fb = ((!sb[k].mem_read || k == NE - 1) &&
            writer_match(sb[k], sb[0].rt, sb[0].uses_rt)) ? FWD_W'(k) : fb;
    end
`endif
  end

  // Entry fields that the selected build does not consult.
  always_comb begin
    unused_sb = 1'b0;
    for (int j = 0; j < NE; j++) begin
      unused_sb = unused_sb ^ (^sb[j]);
    end
  end

  assign stall       = arst_n & haz & ~br_taken;
  assign bubble      = arst_n & (haz | br_taken);
  assign flush_if_id = arst_n & br_taken;
  assign fwd_a       = arst_n ? fa : FWD_W'(FWD_NONE);
  assign fwd_b       = arst_n ? fb : FWD_W'(FWD_NONE);

  // Saturating count of cycles the front end was held.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (enable && stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (5-stage, 7-stage and narrow-counter instances).
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk;
  logic       arst_n, enable, id_valid, id_uses_rs, id_uses_rt;
  logic       id_reg_write, id_mem_read, br_taken;
  logic [4:0] id_rs, id_rt, id_waddr;

  logic        st5, bu5, fl5, st7, bu7, fl7, sts, bus, fls;
  logic [1:0]  fa5, fb5, fas, fbs;
  logic [2:0]  fa7, fb7;
  logic [15:0] cnt5, cnt7;
  logic [3:0]  cnts;

  typedef struct {
    string       tag;
    int          sel;
    logic        st, bu, fl;
    logic [2:0]  fa, fb;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   sel = 0;
  int   exp_cnt = 0;

  hazard_ctrl #(.N_STAGES(5)) u5 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_waddr(id_waddr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
    .stall(st5), .bubble(bu5), .flush_if_id(fl5), .fwd_a(fa5), .fwd_b(fb5), .stall_cnt(cnt5)
  );

  hazard_ctrl #(.N_STAGES(7)) u7 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_waddr(id_waddr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
    .stall(st7), .bubble(bu7), .flush_if_id(fl7), .fwd_a(fa7), .fwd_b(fb7), .stall_cnt(cnt7)
  );

  hazard_ctrl #(.N_STAGES(5), .CNT_W(4)) us (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_waddr(id_waddr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
    .stall(sts), .bubble(bus), .flush_if_id(fls), .fwd_a(fas), .fwd_b(fbs), .stall_cnt(cnts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected timing derived from pipeline depth: stall cycles and forwarding source.
  function automatic int stalls_for(input int n, input bit load);
    if (FWD) return load ? n - 4 : 0;
    return n - 2;
  endfunction

  function automatic int fwd_for(input int n, input bit load);
    if (FWD) return load ? n - 3 : 1;
    return 0;
  endfunction

  task automatic cmp(input string tag, input string what, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic set_idle();
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_waddr = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    br_taken = 1'b0; enable = 1'b1; arst_n = 1'b1;
  endtask

  task automatic set_instr(input int rs, input int rt, input bit urs, input bit urt,
                           input int wa, input bit rw, input bit mr);
    set_idle();
    id_valid = 1'b1; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_waddr = 5'(wa); id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic check_pop();
    exp_t e;
    logic st, bu, fl;
    logic [2:0] fa, fb;
    logic [15:0] cnt;
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = q.pop_front();
    case (e.sel)
      0: begin st = st5; bu = bu5; fl = fl5; fa = {1'b0, fa5}; fb = {1'b0, fb5}; cnt = cnt5; end
      1: begin st = st7; bu = bu7; fl = fl7; fa = fa7; fb = fb7; cnt = cnt7; end
      default: begin
        st = sts; bu = bus; fl = fls; fa = {1'b0, fas}; fb = {1'b0, fbs}; cnt = {12'd0, cnts};
      end
    endcase
    cmp(e.tag, "stall", {15'd0, st}, {15'd0, e.st});
    cmp(e.tag, "bubble", {15'd0, bu}, {15'd0, e.bu});
    cmp(e.tag, "flush", {15'd0, fl}, {15'd0, e.fl});
    cmp(e.tag, "fwd_a", {13'd0, fa}, {13'd0, e.fa});
    cmp(e.tag, "fwd_b", {13'd0, fb}, {13'd0, e.fb});
    cmp(e.tag, "stall_cnt", cnt, e.cnt);
  endtask

  // Inputs are applied at negedge; outputs are sampled 2 time units later.
  task automatic cycle_chk(input string tag, input bit st, input bit bu, input bit fl,
                           input int fa, input int fb, input int cnt);
    exp_t e;
    e.tag = tag; e.sel = sel; e.st = st; e.bu = bu; e.fl = fl;
    e.fa = 3'(fa); e.fb = 3'(fb); e.cnt = 16'(cnt);
    q.push_back(e);
    #2;
    check_pop();
    @(negedge clk);
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle(); arst_n = 1'b0;
    adv(1);
    arst_n = 1'b1; exp_cnt = 0;
  endtask

  // Writer of r5 followed by a reader of r5 that stays in ID until released.
  task automatic raw_seq(input string tag, input int n, input bit load, input bit use_rt);
    int s, f;
    s = stalls_for(n, load);
    f = fwd_for(n, load);
    set_instr(1, 0, 1'b1, 1'b0, 5, 1'b1, load);
    cycle_chk({tag, "_wr"}, 1'b0, 1'b0, 1'b0, 0, 0, exp_cnt);
    for (int i = 0; i < s; i++) begin
      set_instr(use_rt ? 2 : 5, use_rt ? 5 : 2, 1'b1, 1'b1, 6, 1'b1, 1'b0);
      cycle_chk({tag, "_stall"}, 1'b1, 1'b1, 1'b0, 0, 0, exp_cnt);
      exp_cnt++;
    end
    set_instr(use_rt ? 2 : 5, use_rt ? 5 : 2, 1'b1, 1'b1, 6, 1'b1, 1'b0);
    cycle_chk({tag, "_go"}, 1'b0, 1'b0, 1'b0, 0, 0, exp_cnt);
    set_idle();
    cycle_chk({tag, "_fwd"}, 1'b0, 1'b0, 1'b0, use_rt ? 0 : f, use_rt ? f : 0, exp_cnt);
  endtask

  task automatic sat_iter(input int s);
    set_instr(1, 0, 1'b1, 1'b0, 5, 1'b1, 1'b1);
    adv(1);
    set_instr(2, 5, 1'b1, 1'b1, 6, 1'b1, 1'b0);
    adv(s + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s5;
    s5 = stalls_for(5, 1'b1);
    set_idle(); arst_n = 1'b0;
    @(negedge clk);
    set_idle();
    cycle_chk("rst_state", 1'b0, 1'b0, 1'b0, 0, 0, 0);

    raw_seq("alu", 5, 1'b0, 1'b0);
    raw_seq("lu5", 5, 1'b1, 1'b1);

    // Taken branch together with a load-use hazard: flush wins, count untouched.
    set_instr(1, 0, 1'b1, 1'b0, 8, 1'b1, 1'b1);
    cycle_chk("br_ld", 1'b0, 1'b0, 1'b0, 0, 0, exp_cnt);
    set_instr(8, 0, 1'b1, 1'b0, 9, 1'b1, 1'b0); br_taken = 1'b1;
    cycle_chk("br_hz", 1'b0, 1'b1, 1'b1, 0, 0, exp_cnt);
    set_idle();
    cycle_chk("br_after", 1'b0, 1'b0, 1'b0, 0, 0, exp_cnt);
    adv(6);

    // Frozen pipeline keeps the hazard visible but does not count it.
    set_instr(1, 0, 1'b1, 1'b0, 10, 1'b1, 1'b1);
    cycle_chk("en_ld", 1'b0, 1'b0, 1'b0, 0, 0, exp_cnt);
    set_instr(10, 0, 1'b1, 1'b0, 11, 1'b1, 1'b0); enable = 1'b0;
    cycle_chk("en_frz0", 1'b1, 1'b1, 1'b0, 0, 0, exp_cnt);
    set_instr(10, 0, 1'b1, 1'b0, 11, 1'b1, 1'b0); enable = 1'b0;
    cycle_chk("en_frz1", 1'b1, 1'b1, 1'b0, 0, 0, exp_cnt);
    set_instr(10, 0, 1'b1, 1'b0, 11, 1'b1, 1'b0);
    cycle_chk("en_run", 1'b1, 1'b1, 1'b0, 0, 0, exp_cnt);
    exp_cnt++;
    set_idle();
    cycle_chk("en_cnt", 1'b0, 1'b0, 1'b0, 0, 0, exp_cnt);
    adv(6);

    // Register 0 writes never create a dependency.
    set_instr(1, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    cycle_chk("r0_wr", 1'b0, 1'b0, 1'b0, 0, 0, exp_cnt);
    set_instr(0, 0, 1'b1, 1'b1, 6, 1'b1, 1'b0);
    cycle_chk("r0_rd", 1'b0, 1'b0, 1'b0, 0, 0, exp_cnt);
    set_idle();
    cycle_chk("r0_fwd", 1'b0, 1'b0, 1'b0, 0, 0, exp_cnt);
    adv(6);

    // Counter saturation on the 4-bit instance while the 16-bit one keeps counting.
    do_reset();
    repeat (17) sat_iter(s5);
    set_idle(); adv(6);
    sel = 2;
    cycle_chk("sat_cnt", 1'b0, 1'b0, 1'b0, 0, 0, 15);
    sel = 0;
    cycle_chk("sat_u5", 1'b0, 1'b0, 1'b0, 0, 0, 17 * s5);
    sat_iter(s5);
    set_idle(); adv(6);
    sel = 2;
    cycle_chk("sat_hold", 1'b0, 1'b0, 1'b0, 0, 0, 15);
    sel = 0;

    // Reset with a load in flight and a dependent reader in ID.
    set_instr(1, 0, 1'b1, 1'b0, 5, 1'b1, 1'b1);
    adv(1);
    set_instr(5, 0, 1'b1, 1'b0, 6, 1'b1, 1'b0); arst_n = 1'b0;
    cycle_chk("rst_fl", 1'b0, 1'b0, 1'b0, 0, 0, 18 * s5);
    set_instr(5, 0, 1'b1, 1'b0, 6, 1'b1, 1'b0);
    cycle_chk("rst_after", 1'b0, 1'b0, 1'b0, 0, 0, 0);

    // Seven-stage pipeline.
    do_reset();
    sel = 1;
    raw_seq("lu7", 7, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
